// File: rtl/demux_1_to_3.sv
// demux_1_to_3
//   Routes one incoming word per cycle to one of three registered destinations,
//   or discards it and counts the discard.
//
// Ports
//   clk                 single clock, rising edge only
//   rst                 synchronous active-high reset
//   data_in [WIDTH]     word to route
//   select  [2]         00/01/10 -> out0/out1/out2, 11 -> discard
//   valid_in            data_in/select are offered this cycle
//   ready_in            block accepts the offered word this cycle (combinational)
//   data_outK [WIDTH]   holding register for destination K
//   valid_outK          data_outK holds an undelivered word
//   ready_outK          destination K consumes data_outK this cycle
//   drop_count [8]      saturating count of discarded words

module demux_1_to_3 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       select,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             valid_out2,
    input  logic             ready_out0,
    input  logic             ready_out1,
    input  logic             ready_out2,
    output logic [7:0]       drop_count
);

    logic [2:0][WIDTH-1:0] data_q;
    logic [2:0][WIDTH-1:0] data_d;
    logic [2:0]            valid_q;
    logic [2:0]            valid_d;
    logic [2:0]            ready_out;
    logic [7:0]            drop_q;
    logic [7:0]            drop_d;
    logic                  accept;

    assign ready_out = {ready_out2, ready_out1, ready_out0};

    // A destination can take a word when its slot is empty or is being
    // emptied on this same edge; valid_in is deliberately not a term here.
    always_comb begin
        ready_in = 1'b1;
        case (select)
            2'b00:   ready_in = !valid_q[0] || ready_out[0];
            2'b01:   ready_in = !valid_q[1] || ready_out[1];
            2'b10:   ready_in = !valid_q[2] || ready_out[2];
            default: ready_in = 1'b1;
        endcase
    end

    assign accept = valid_in && ready_in;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int k = 0; k < 3; k++) begin
            if (valid_q[k] && ready_out[k]) begin
                valid_d[k] = 1'b0;
            end
            // A load on the draining edge overrides the clear, giving one
            // word per cycle per destination.
            if (accept && (select == 2'(k))) begin
                data_d[k]  = data_in;
                valid_d[k] = 1'b1;
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (accept && (select == 2'b11) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign data_out0  = data_q[0];
    assign data_out1  = data_q[1];
    assign data_out2  = data_q[2];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign drop_count = drop_q;

endmodule
